// File: rtl/xm_mem_interface.sv
// xm_mem_interface: single-request memory bus unit with byte-lane steering for the XM core.
// Define XM_MEM_TIMEOUT_EN to abort stalled bus accesses after TIMEOUT cycles with busErr_o.
module xm_mem_interface #(
   parameter int WORD    = 16,
   parameter int TIMEOUT = 15
) (
   input  logic            clk_i,
   input  logic            arst_i,
   input  logic            memEn_i,
   input  logic            memRW_i,
   input  logic            byteOp_i,
   input  logic [WORD-1:0] adr_i,
   input  logic [WORD-1:0] wrData_i,
   output logic            memBusy_o,
   output logic [WORD-1:0] rdData_o,
   output logic            rdValid_o,
   output logic            alnErr_o,
   output logic            busErr_o,
   output logic            busReq_o,
   output logic            busWe_o,
   output logic [WORD-1:0] busAdr_o,
   output logic [1:0]      busByteEn_o,
   output logic [WORD-1:0] busWrData_o,
   input  logic [WORD-1:0] busRdData_i,
   input  logic            busAck_i
);
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t state_q, state_d;
   logic accept, aln, done, tmo;
   logic [WORD-1:0] rd_lane;
`ifdef XM_MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q;
`endif
   assign memBusy_o = (state_q == ACCESS);
   assign busReq_o  = (state_q == ACCESS);
   // The latched lane enables double as the record of access size and byte position.
   assign rd_lane = busByteEn_o == 2'b11 ? busRdData_i :
                    busByteEn_o[1] ? {8'h00, busRdData_i[15:8]} : {8'h00, busRdData_i[7:0]};
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      aln     = 1'b0;
      done    = 1'b0;
      tmo     = 1'b0;
      if (state_q == IDLE) begin
         aln     = memEn_i && !byteOp_i && adr_i[0];
         accept  = memEn_i && !aln;
         state_d = accept ? ACCESS : IDLE;
      end else if (busAck_i) begin
         done    = 1'b1;
         state_d = IDLE;
      end
`ifdef XM_MEM_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT - 1)) begin
         tmo     = 1'b1;
         state_d = IDLE;
      end
`endif
   end
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state_q     <= IDLE;
         rdData_o    <= '0;
         rdValid_o   <= 1'b0;
         alnErr_o    <= 1'b0;
         busWe_o     <= 1'b0;
         busAdr_o    <= '0;
         busByteEn_o <= 2'b00;
         busWrData_o <= '0;
      end else begin
         state_q   <= state_d;
         alnErr_o  <= aln;
         rdValid_o <= done && !busWe_o;
         if (done && !busWe_o) rdData_o <= rd_lane;
         if (accept) begin
            busWe_o     <= memRW_i;
            busAdr_o    <= {adr_i[WORD-1:1], 1'b0};
            busByteEn_o <= byteOp_i ? (adr_i[0] ? 2'b10 : 2'b01) : 2'b11;
            busWrData_o <= byteOp_i ? {2{wrData_i[7:0]}} : wrData_i;
         end
      end
   end
`ifdef XM_MEM_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         cnt_q    <= '0;
         busErr_o <= 1'b0;
      end else begin
         cnt_q    <= accept ? '0 : (state_q == ACCESS ? cnt_q + 1'b1 : cnt_q);
         busErr_o <= tmo;
      end
   end
`else
   assign busErr_o = 1'b0;
`endif
endmodule

// File: tb/tb_xm_mem_interface.sv
// tb_xm_mem_interface: directed table, randomized transactions against a transaction-level model,
// plus reset, stale-ack and timeout sequences.
module tb_xm_mem_interface;
   logic        clk_i = 1'b0, arst_i = 1'b0;
   logic        memEn_i = 1'b0, memRW_i = 1'b0, byteOp_i = 1'b0, busAck_i = 1'b0;
   logic [15:0] adr_i = '0, wrData_i = '0, busRdData_i = '0;
   logic        memBusy_o, rdValid_o, alnErr_o, busErr_o, busReq_o, busWe_o;
   logic [15:0] rdData_o, busAdr_o, busWrData_o;
   logic [1:0]  busByteEn_o;
   int checks = 0, failures = 0;
   logic [15:0] model_rd = '0;

   typedef struct {
      logic rw, bt; logic [15:0] adr, wd; int dly; logic [15:0] brd;
      logic aln; logic [1:0] en; logic [15:0] badr, bwd, rd; logic valid;
   } vec_t;
   vec_t tbl[7];

   xm_mem_interface dut (
      .clk_i(clk_i), .arst_i(arst_i), .memEn_i(memEn_i), .memRW_i(memRW_i), .byteOp_i(byteOp_i),
      .adr_i(adr_i), .wrData_i(wrData_i), .memBusy_o(memBusy_o), .rdData_o(rdData_o),
      .rdValid_o(rdValid_o), .alnErr_o(alnErr_o), .busErr_o(busErr_o), .busReq_o(busReq_o),
      .busWe_o(busWe_o), .busAdr_o(busAdr_o), .busByteEn_o(busByteEn_o), .busWrData_o(busWrData_o),
      .busRdData_i(busRdData_i), .busAck_i(busAck_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic garbage_req();
      memEn_i  = 1'b1;
      memRW_i  = 1'($urandom);
      byteOp_i = 1'($urandom);
      adr_i    = 16'($urandom);
      wrData_i = 16'($urandom);
   endtask

   task automatic run_txn(input vec_t v);
      memEn_i = 1'b1; memRW_i = v.rw; byteOp_i = v.bt; adr_i = v.adr; wrData_i = v.wd;
      step();
      memEn_i = 1'b0;
      if (v.aln) begin
         chk("aln_pulse", alnErr_o, 1'b1);
         chk("aln_req", busReq_o, 1'b0);
         chk("aln_busy", memBusy_o, 1'b0);
         chk("aln_rdvalid", rdValid_o, 1'b0);
         step();
         chk("aln_width", alnErr_o, 1'b0);
         chk("aln_req2", busReq_o, 1'b0);
         chk("aln_busy2", memBusy_o, 1'b0);
         chk("aln_rddata", rdData_o, v.rd);
      end else begin
         chk("acc_busy", memBusy_o, 1'b1);
         chk("acc_req", busReq_o, 1'b1);
         chk("acc_adr", busAdr_o, v.badr);
         chk("acc_en", busByteEn_o, v.en);
         chk("acc_we", busWe_o, v.rw);
         chk("acc_wdata", busWrData_o, v.bwd);
         chk("acc_rdvalid", rdValid_o, 1'b0);
         chk("acc_aln", alnErr_o, 1'b0);
         for (int i = 1; i < v.dly; i++) begin
            garbage_req();
            step();
            chk("wait_req", busReq_o, 1'b1);
            chk("wait_adr", busAdr_o, v.badr);
            chk("wait_en", busByteEn_o, v.en);
            chk("wait_wdata", busWrData_o, v.bwd);
            chk("wait_pulses", {alnErr_o, busErr_o, rdValid_o}, 3'b000);
         end
         garbage_req();
         busAck_i = 1'b1; busRdData_i = v.brd;
         step();
         memEn_i = 1'b0; busAck_i = 1'b0;
         chk("done_req", busReq_o, 1'b0);
         chk("done_busy", memBusy_o, 1'b0);
         chk("done_rdvalid", rdValid_o, v.valid);
         chk("done_rddata", rdData_o, v.rd);
         chk("done_errs", {alnErr_o, busErr_o}, 2'b00);
      end
      model_rd = v.rd;
   endtask

   function automatic vec_t model(input logic rw, bt, input logic [15:0] adr, wd, input int dly,
                                  input logic [15:0] brd, input logic [15:0] prev_rd);
      vec_t v;
      int sh;
      v.rw = rw; v.bt = bt; v.adr = adr; v.wd = wd; v.dly = dly; v.brd = brd;
      sh = 8 * (adr % 2);
      v.aln   = !bt && (adr % 2 == 1);
      v.en    = bt ? 2'(1 << (adr % 2)) : 2'd3;
      v.badr  = 16'(adr - adr % 2);
      v.bwd   = bt ? 16'((wd % 256) * 257) : wd;
      v.valid = !v.aln && !rw;
      v.rd    = v.valid ? (bt ? 16'((brd >> sh) % 256) : brd) : prev_rd;
      return v;
   endfunction

   initial begin
      tbl[0] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 3, 16'hBEEF, 1'b0, 2'b11, 16'h0100, 16'h0000, 16'hBEEF, 1'b1};
      tbl[1] = '{1'b1, 1'b1, 16'h0201, 16'h00A5, 1, 16'h0000, 1'b0, 2'b10, 16'h0200, 16'hA5A5, 16'hBEEF, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 16'h0203, 16'h0000, 2, 16'h7F12, 1'b0, 2'b10, 16'h0202, 16'h0000, 16'h007F, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 16'h0202, 16'h0000, 1, 16'h7F12, 1'b0, 2'b01, 16'h0202, 16'h0000, 16'h0012, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 16'h0105, 16'h1234, 0, 16'h0000, 1'b1, 2'b00, 16'h0000, 16'h0000, 16'h0012, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 16'h0400, 16'h1234, 2, 16'hFFFF, 1'b0, 2'b11, 16'h0400, 16'h1234, 16'h0012, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 16'h0010, 16'hFF3C, 4, 16'h0000, 1'b0, 2'b01, 16'h0010, 16'h3C3C, 16'h0012, 1'b0};
      #3;
      chk("rst_req", busReq_o, 1'b0);
      chk("rst_busy", memBusy_o, 1'b0);
      chk("rst_rddata", rdData_o, 16'h0000);
      chk("rst_pulses", {alnErr_o, busErr_o, rdValid_o}, 3'b000);
      chk("rst_bus", {busWe_o, busByteEn_o}, 3'b000);
      chk("rst_adr", busAdr_o, 16'h0000);
      chk("rst_wdata", busWrData_o, 16'h0000);
      step();
      arst_i = 1'b1;
      foreach (tbl[i]) run_txn(tbl[i]);
      for (int n = 0; n < 80; n++)
         run_txn(model(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                       int'($urandom_range(1, 6)), 16'($urandom), model_rd));
      // reset abandons an access in flight
      run_txn(model(1'b0, 1'b0, 16'h0040, 16'h0, 1, 16'h4321, model_rd));
      memEn_i = 1'b1; memRW_i = 1'b0; byteOp_i = 1'b0; adr_i = 16'h0010;
      step();
      memEn_i = 1'b0;
      step();
      chk("pre_rst_req", busReq_o, 1'b1);
      #2 arst_i = 1'b0;
      #1;
      chk("arst_req", busReq_o, 1'b0);
      chk("arst_busy", memBusy_o, 1'b0);
      chk("arst_rddata", rdData_o, 16'h0000);
      chk("arst_pulses", {alnErr_o, busErr_o, rdValid_o}, 3'b000);
      model_rd = '0;
      #1 arst_i = 1'b1;
      run_txn(model(1'b0, 1'b1, 16'h0033, 16'h0, 2, 16'h9A5C, model_rd));
      // stale ack in IDLE
      busAck_i = 1'b1; busRdData_i = 16'hDEAD;
      step();
      busAck_i = 1'b0;
      chk("stale_req", busReq_o, 1'b0);
      chk("stale_busy", memBusy_o, 1'b0);
      chk("stale_rdvalid", rdValid_o, 1'b0);
      chk("stale_rddata", rdData_o, model_rd);
      step();
      chk("stale_rdvalid2", rdValid_o, 1'b0);
`ifdef XM_MEM_TIMEOUT_EN
      memEn_i = 1'b1; memRW_i = 1'b0; byteOp_i = 1'b0; adr_i = 16'h0300;
      step();
      memEn_i = 1'b0;
      for (int i = 1; i < 15; i++) begin
         step();
         chk("tmo_wait_req", busReq_o, 1'b1);
         chk("tmo_wait_err", busErr_o, 1'b0);
      end
      step();
      chk("tmo_req", busReq_o, 1'b0);
      chk("tmo_busy", memBusy_o, 1'b0);
      chk("tmo_err", busErr_o, 1'b1);
      chk("tmo_rdvalid", rdValid_o, 1'b0);
      chk("tmo_rddata", rdData_o, model_rd);
      step();
      chk("tmo_width", busErr_o, 1'b0);
      run_txn(model(1'b0, 1'b0, 16'h0302, 16'h0, 15, 16'h5A5A, model_rd));
`else
      run_txn(model(1'b0, 1'b0, 16'h0302, 16'h0, 20, 16'h5A5A, model_rd));
`endif
      run_txn(model(1'b0, 1'b0, 16'h0304, 16'h0, 1, 16'hC0DE, model_rd));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
